// File: rtl/mips_boot_pkg.sv
// Shared types and constants for the boot-time imem loader.
// Stream: 2 length bytes, 4*N big-endian payload bytes, 1 XOR checksum byte.
package mips_boot_pkg;

  typedef enum logic [2:0] {
    S_LEN_HI,
    S_LEN_LO,
    S_DATA,
    S_CSUM,
    S_RUN,
    S_ERR
  } boot_state_t;

  localparam int LEN_BYTES  = 2;
  localparam int WORD_BYTES = 4;
  localparam int CSUM_W     = 8;

endpackage

// File: rtl/mips_boot_if.sv
// Byte-stream input and imem write port of the boot loader.
// master = loader side, slave = stream source / instruction memory side.
interface mips_boot_if #(parameter int ADDR_W = 10);
  logic              rx_valid;
  logic [7:0]        rx_data;
  logic              rx_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;

  modport master (
    input  rx_valid, rx_data,
    output rx_ready, imem_we, imem_addr, imem_wdata
  );

  modport slave (
    output rx_valid, rx_data,
    input  rx_ready, imem_we, imem_addr, imem_wdata
  );
endinterface

// File: rtl/mips_boot_loader_packer.sv
// Byte-to-word packer: holds the first three bytes of a word and presents the
// completed big-endian word combinationally alongside the fourth byte.
module boot_word_packer
  import mips_boot_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clr,
  input  logic        byte_vld,
  input  logic [7:0]  byte_in,
  output logic [31:0] word,
  output logic        word_valid
);

  logic [23:0] sh;
  logic [1:0]  cnt;

  assign word       = {sh, byte_in};
  assign word_valid = byte_vld && (cnt == 2'(WORD_BYTES - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sh  <= '0;
      cnt <= '0;
    end else if (clr) begin
      sh  <= '0;
      cnt <= '0;
    end else if (byte_vld) begin
      sh  <= word[23:0];
      cnt <= cnt + 2'd1;
    end
  end

endmodule

// File: rtl/mips_boot_loader.sv
// Boot loader: parses the length/payload/checksum stream, writes words into
// imem from address 0 and holds the core in reset until a valid image lands.
module mips_boot_loader
  import mips_boot_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic       clk,
  input  logic       reset,
  mips_boot_if.master bus,
  output logic       core_reset,
  output logic       done,
  output logic       err
);

  localparam logic [16:0] MAX_WORDS = 17'(1) << ADDR_W;

  boot_state_t       state;
  logic [7:0]        len_hi;
  logic [15:0]       words_left;
  logic [ADDR_W-1:0] waddr;
  logic [CSUM_W-1:0] csum;

  logic        accept;
  logic        byte_vld;
  logic        pk_clr;
  logic        word_valid;
  logic [31:0] word;
  logic [15:0] n;

  assign accept   = bus.rx_valid && bus.rx_ready;
  assign n        = {len_hi, bus.rx_data};
  assign pk_clr   = (state == S_LEN_HI);
  assign byte_vld = accept && (state == S_DATA);

  boot_word_packer u_packer (
    .clk        (clk),
    .reset      (reset),
    .clr        (pk_clr),
    .byte_vld   (byte_vld),
    .byte_in    (bus.rx_data),
    .word       (word),
    .word_valid (word_valid)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= S_LEN_HI;
      len_hi         <= '0;
      words_left     <= '0;
      waddr          <= '0;
      csum           <= '0;
      bus.rx_ready   <= 1'b0;
      bus.imem_we    <= 1'b0;
      bus.imem_addr  <= '0;
      bus.imem_wdata <= '0;
      core_reset     <= 1'b1;
      done           <= 1'b0;
      err            <= 1'b0;
    end else begin
      bus.imem_we <= 1'b0;
      case (state)
        S_LEN_HI: begin
          // Only reachable from reset, so this is also the clear point.
          bus.rx_ready <= 1'b1;
          csum         <= '0;
          waddr        <= '0;
          if (accept) begin
            len_hi <= bus.rx_data;
            state  <= S_LEN_LO;
          end
        end
        S_LEN_LO: begin
          if (accept) begin
            words_left <= n;
            if ({1'b0, n} > MAX_WORDS) begin
              state        <= S_ERR;
              bus.rx_ready <= 1'b0;
              err          <= 1'b1;
            end else if (n == 16'd0) begin
              state <= S_CSUM;
            end else begin
              state <= S_DATA;
            end
          end
        end
        S_DATA: begin
          if (accept) begin
            csum <= csum ^ bus.rx_data;
            if (word_valid) begin
              bus.imem_we    <= 1'b1;
              bus.imem_addr  <= waddr;
              bus.imem_wdata <= word;
              waddr          <= waddr + 1'b1;
              words_left     <= words_left - 16'd1;
              if (words_left == 16'd1)
                state <= S_CSUM;
            end
          end
        end
        S_CSUM: begin
          if (accept) begin
            bus.rx_ready <= 1'b0;
            if (bus.rx_data == csum) begin
              state      <= S_RUN;
              core_reset <= 1'b0;
              done       <= 1'b1;
            end else begin
              state <= S_ERR;
              err   <= 1'b1;
            end
          end
        end
        S_RUN, S_ERR: bus.rx_ready <= 1'b0;
        default: state <= S_ERR;
      endcase
    end
  end

endmodule
